posit_decode_pipe: RTL

- Two-stage, elastic, pipelined posit-to-fields decoder; the decode counterpart to the int-to-posit encode path of the posit cast unit.
- Unpacks a WIDTH-bit posit (ES exponent bits) into sign, combined scale (k*2^ES + e), hidden-bit mantissa and special flags.
- Sits in front of the posit-to-int cast and the arithmetic units, with the same valid/ready/flush/busy handshake as the cast unit.

---
 rtl/posit_pkg.sv | 20 ++
 rtl/posit_regime_lzc.sv | 28 ++
 rtl/posit_decode_pipe.sv | 135 +++++++++++++
 3 files changed

// File: rtl/posit_pkg.sv
// Shared posit definitions for the decode pipeline and the cast unit.
package posit_pkg;

    localparam int unsigned POSIT_WIDTH   = 32;
    localparam int unsigned POSIT_ES      = 2;
    localparam int unsigned POSIT_MANT_W  = POSIT_WIDTH - POSIT_ES - 2;
    localparam int unsigned POSIT_SCALE_W = $clog2(POSIT_WIDTH) + POSIT_ES + 1;

    localparam logic [POSIT_WIDTH-1:0] posit_zero = '0;
    localparam logic [POSIT_WIDTH-1:0] posit_nar  = {1'b1, {(POSIT_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic                             sign;
        logic signed [POSIT_SCALE_W-1:0]  scale;
        logic        [POSIT_MANT_W-1:0]   mant;
        logic                             zero;
        logic                             nar;
    } decoded_posit_t;

endpackage

// File: rtl/posit_regime_lzc.sv
// Leading-run counter: polarity of the top bit and the length of the run of
// identical bits starting there (minimum 1, maximum N).
module posit_regime_lzc #(
    parameter int unsigned N = 31,
    localparam int unsigned CNT_W = $clog2(N + 1)
) (
    input  logic [N-1:0]     bits,
    output logic             polarity,
    output logic [CNT_W-1:0] count
);

    always_comb begin
        logic pol;
        logic run;
        pol   = bits[N-1];
        run   = 1'b1;
        count = CNT_W'(1);
        for (int i = int'(N) - 2; i >= 0; i--) begin
            if (run && (bits[i] == pol)) begin
                count = count + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
        polarity = pol;
    end

endmodule

// File: rtl/posit_decode_pipe.sv
// Two-stage elastic posit-to-fields decoder (sign, scale, hidden-bit mantissa).
// Optional operand tag sideband enabled by defining POSIT_DECODE_TAG_EN.
module posit_decode_pipe
    import posit_pkg::*;
#(
    parameter int unsigned WIDTH = POSIT_WIDTH,
    parameter int unsigned ES    = POSIT_ES,
`ifdef POSIT_DECODE_TAG_EN
    parameter int unsigned TAG_W = 4,
`endif
    localparam int unsigned MANT_W  = WIDTH - ES - 2,
    localparam int unsigned SCALE_W = $clog2(WIDTH) + ES + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [WIDTH-1:0]          operand_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic                      flush_i,
`ifdef POSIT_DECODE_TAG_EN
    input  logic [TAG_W-1:0]          tag_i,
    output logic [TAG_W-1:0]          tag_o,
`endif
    output logic                      sign_o,
    output logic signed [SCALE_W-1:0] scale_o,
    output logic [MANT_W-1:0]         mant_o,
    output logic                      zero_o,
    output logic                      nar_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      busy_o
);

    localparam int unsigned N      = WIDTH - 1;
    localparam int unsigned CNT_W  = $clog2(N + 1);
    localparam int unsigned TAIL_W = N - 2;

    logic                     s1_valid, s2_valid;
    logic                     s1_sign, s1_zero, s1_nar;
    logic [N-1:0]             s1_body;
    logic                     s2_can_load, s1_can_load, s1_load, s2_load;
    logic                     run_pol;
    logic [CNT_W-1:0]         run_len;
    logic [TAIL_W-1:0]        tail_c;
    logic [ES-1:0]            exp_c;
    logic [MANT_W-2:0]        frac_c;
    logic signed [SCALE_W-1:0] k_c, scale_c;
    logic                     special_c;
`ifdef POSIT_DECODE_TAG_EN
    logic [TAG_W-1:0]         s1_tag;
`endif

    // Elastic handshake: a stage loads when empty or draining this cycle.
    assign s2_can_load = !s2_valid || out_ready_i;
    assign s1_can_load = !s1_valid || s2_can_load;
    assign in_ready_o  = flush_i || s1_can_load;
    assign s1_load     = in_valid_i && s1_can_load && !flush_i;
    assign s2_load     = s1_valid && s2_can_load && !flush_i;
    assign out_valid_o = s2_valid;
    assign busy_o      = s1_valid | s2_valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (flush_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_can_load) s2_valid <= s1_valid;
            if (s1_can_load) s1_valid <= in_valid_i;
        end
    end

    // S1: sign, magnitude below the sign bit, special detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_sign <= 1'b0;
            s1_body <= '0;
            s1_zero <= 1'b0;
            s1_nar  <= 1'b0;
        end else if (s1_load) begin
            s1_sign <= operand_i[WIDTH-1];
            s1_body <= operand_i[WIDTH-1] ? N'(-operand_i) : operand_i[N-1:0];
            s1_zero <= (operand_i == '0);
            s1_nar  <= (operand_i == {1'b1, {(WIDTH-1){1'b0}}});
        end
    end

    posit_regime_lzc #(.N(N)) u_regime_lzc (
        .bits     (s1_body),
        .polarity (run_pol),
        .count    (run_len)
    );

    // Regime + terminator occupy run_len+1 bits; the two MSBs of the body are
    // always consumed, so the tail shift is run_len-1 on the remaining bits.
    always_comb begin
        tail_c    = s1_body[TAIL_W-1:0] << (run_len - CNT_W'(1));
        exp_c     = tail_c[TAIL_W-1 -: ES];
        frac_c    = tail_c[MANT_W-2:0];
        k_c       = run_pol ? (SCALE_W'(run_len) - SCALE_W'(1)) : -SCALE_W'(run_len);
        scale_c   = (k_c <<< ES) + SCALE_W'(exp_c);
        special_c = s1_zero | s1_nar;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sign_o  <= 1'b0;
            scale_o <= '0;
            mant_o  <= '0;
            zero_o  <= 1'b0;
            nar_o   <= 1'b0;
        end else if (s2_load) begin
            sign_o  <= special_c ? s1_nar : s1_sign;
            scale_o <= special_c ? '0 : scale_c;
            mant_o  <= special_c ? '0 : {1'b1, frac_c};
            zero_o  <= s1_zero;
            nar_o   <= s1_nar;
        end
    end

`ifdef POSIT_DECODE_TAG_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_tag <= '0;
            tag_o  <= '0;
        end else begin
            if (s1_load) s1_tag <= tag_i;
            if (s2_load) tag_o  <= s1_tag;
        end
    end
`endif

endmodule
